// File: rtl/nvic_pkg.sv
// Shared definitions for the NVIC controller: FSM state encoding, default
// source count and the encoded-number width helper.
package nvic_pkg;

  localparam int NVIC_NUM_IRQ_DEFAULT = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } nvic_state_e;

  // Width needed to encode IRQ numbers 0..n, where 0 means "none".
  function automatic int enc_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nvic_ctrl_if.sv
// Core-side handshake of the NVIC controller: global enable, req/ack/done
// and the IRQ number being requested or serviced.
interface nvic_ctrl_if
  import nvic_pkg::*;
#(
  parameter int ENC_W = enc_w(NVIC_NUM_IRQ_DEFAULT)
);

  logic             i_gie;
  logic             i_ack;
  logic             i_done;
  logic             o_req;
  logic [ENC_W-1:0] o_num;
  logic             o_active;

  // Controller side.
  modport slave (
    input  i_gie, i_ack, i_done,
    output o_req, o_num, o_active
  );

  // Core side.
  modport master (
    output i_gie, i_ack, i_done,
    input  o_req, o_num, o_active
  );

endinterface

// File: rtl/nvic_prio_enc.sv
// Combinational highest-wins encoder: returns (highest set index)+1, or 0
// when no input is set. Generalises the fixed 11-input encoder.
module nvic_prio_enc
  import nvic_pkg::*;
#(
  parameter  int NUM_IRQ = NVIC_NUM_IRQ_DEFAULT,
  localparam int ENC_W   = enc_w(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic [ENC_W-1:0]   o_num
);

  // NOTE: o_num gets a default before the loop so every path assigns it and
  // no latch is inferred; later (higher) indices overwrite earlier ones.
  always_comb begin
    o_num = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (i_req[i]) o_num = ENC_W'(i + 1);
    end
  end

endmodule

// File: rtl/nvic_ctrl.sv
// Parametrised interrupt controller: edge capture into pending bits, enable
// mask, highest-number selection and a single-level req/ack/done handshake.
module nvic_ctrl
  import nvic_pkg::*;
#(
  parameter int NUM_IRQ = NVIC_NUM_IRQ_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_maskWr,
  input  logic [NUM_IRQ-1:0] i_maskData,
  output logic [NUM_IRQ-1:0] o_pend,
  nvic_ctrl_if.slave         core
);

  localparam int ENC_W = enc_w(NUM_IRQ);

  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_mask;
  nvic_state_e        r_state;
  logic [ENC_W-1:0]   r_num;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_cand;
  logic [NUM_IRQ-1:0] w_clr;
  logic [ENC_W-1:0]   w_sel_num;
  nvic_state_e        w_state_nxt;
  logic [ENC_W-1:0]   w_num_nxt;

  assign w_rise = i_irq & ~r_irq_prev;
  assign w_cand = r_pend & r_mask;

  nvic_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .i_req (w_cand),
    .o_num (w_sel_num)
  );

  // NOTE: all state, including irq_prev, is cleared by the async reset so a
  // line already high when reset releases is seen as a fresh rise.
  // Non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_irq_prev <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_state    <= ST_IDLE;
      r_num      <= '0;
    end else begin
      r_irq_prev <= i_irq;
      r_pend     <= (r_pend & ~w_clr) | w_rise;
      if (i_maskWr) r_mask <= i_maskData;
      r_state    <= w_state_nxt;
      r_num      <= w_num_nxt;
    end
  end

  // Once in REQ the number is frozen; only the handshake moves the FSM on.
  always_comb begin
    w_state_nxt = r_state;
    w_num_nxt   = r_num;
    w_clr       = '0;
    case (r_state)
      ST_IDLE: begin
        if (core.i_gie && (w_sel_num != '0)) begin
          w_state_nxt = ST_REQ;
          w_num_nxt   = w_sel_num;
        end
      end
      ST_REQ: begin
        if (core.i_ack) begin
          w_state_nxt = ST_ACTIVE;
          w_clr       = {{(NUM_IRQ-1){1'b0}}, 1'b1} << (r_num - ENC_W'(1));
        end
      end
      ST_ACTIVE: begin
        if (core.i_done) begin
          w_state_nxt = ST_IDLE;
          w_num_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_num_nxt   = '0;
      end
    endcase
  end

  assign o_pend        = r_pend;
  assign core.o_req    = (r_state == ST_REQ);
  assign core.o_active = (r_state == ST_ACTIVE);
  assign core.o_num    = r_num;

endmodule

// File: tb/tb_nvic_ctrl.sv
// Self-checking bench for nvic_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the controller.
module tb_nvic_ctrl;
  import nvic_pkg::*;

  localparam int N    = 11;
  localparam int EW   = enc_w(N);
  localparam int N16  = 16;
  localparam int EW16 = enc_w(N16);

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  irq;
  logic          mask_wr;
  logic [N-1:0]  mask_data;
  logic [N-1:0]  pend;

  logic           [N16-1:0] irq16;
  logic                     mask_wr16;
  logic           [N16-1:0] mask_data16;
  logic           [N16-1:0] pend16;

  nvic_ctrl_if #(.ENC_W(EW))   core_if   ();
  nvic_ctrl_if #(.ENC_W(EW16)) core_if16 ();

  nvic_ctrl #(.NUM_IRQ(N)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_irq      (irq),
    .i_maskWr   (mask_wr),
    .i_maskData (mask_data),
    .o_pend     (pend),
    .core       (core_if)
  );

  nvic_ctrl #(.NUM_IRQ(N16)) dut16 (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_irq      (irq16),
    .i_maskWr   (mask_wr16),
    .i_maskData (mask_data16),
    .o_pend     (pend16),
    .core       (core_if16)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: pending/mask as bit vectors, handshake as two flags.
  bit [N-1:0] m_pend, m_mask, m_prev;
  bit         m_req, m_active;
  int         m_num;

  function automatic int best_candidate();
    for (int k = N - 1; k >= 0; k--)
      if (m_pend[k] && m_mask[k]) return k + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0;
    m_req = 0; m_active = 0; m_num = 0;
  endtask

  task automatic model_clock();
    bit [N-1:0] rise, clr;
    int sel;
    rise = irq & ~m_prev;
    clr  = '0;
    sel  = best_candidate();
    if (m_active) begin
      if (core_if.i_done) begin m_active = 0; m_num = 0; end
    end else if (m_req) begin
      if (core_if.i_ack) begin m_req = 0; m_active = 1; clr[m_num-1] = 1'b1; end
    end else if (core_if.i_gie && sel != 0) begin
      m_req = 1; m_num = sel;
    end
    m_pend = (m_pend & ~clr) | rise;
    m_prev = irq;
    if (mask_wr) m_mask = mask_data;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".req"},    core_if.o_req,    m_req);
    check({tag, ".active"}, core_if.o_active, m_active);
    check({tag, ".num"},    core_if.o_num,    m_num);
    check({tag, ".pend"},   pend,             m_pend);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    compare_all(tag);
  endtask

  task automatic pulse(input int idx, input string tag);
    irq[idx] = 1'b1;
    step({tag, ".hi"});
    irq[idx] = 1'b0;
  endtask

  task automatic ack_done(input string tag);
    core_if.i_ack = 1'b1;  step({tag, ".ack"});  core_if.i_ack  = 1'b0;
    core_if.i_done = 1'b1; step({tag, ".done"}); core_if.i_done = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; irq = '0; mask_wr = 1'b0; mask_data = '0;
    core_if.i_gie = 1'b0; core_if.i_ack = 1'b0; core_if.i_done = 1'b0;
    irq16 = '0; mask_wr16 = 1'b0; mask_data16 = '0;
    core_if16.i_gie = 1'b0; core_if16.i_ack = 1'b0; core_if16.i_done = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    rstn = 1'b1;

    // 1: single IRQ 5 through the full handshake
    mask_wr = 1'b1; mask_data = '1; core_if.i_gie = 1'b1;
    step("t1.mask");
    mask_wr = 1'b0;
    pulse(4, "t1");
    check("t1.pend4_e0", pend[4], 1'b1);
    check("t1.req_e0", core_if.o_req, 1'b0);
    step("t1.e1");
    check("t1.req_e1", core_if.o_req, 1'b1);
    check("t1.num_e1", core_if.o_num, 5);
    core_if.i_ack = 1'b1; step("t1.ack"); core_if.i_ack = 1'b0;
    check("t1.active", core_if.o_active, 1'b1);
    check("t1.pend4_clr", pend[4], 1'b0);
    core_if.i_done = 1'b1; step("t1.done"); core_if.i_done = 1'b0;
    check("t1.num_idle", core_if.o_num, 0);

    // 2: simultaneous rises, highest first
    irq[1] = 1'b1; irq[9] = 1'b1;
    step("t2.rise");
    irq = '0;
    step("t2.sel");
    check("t2.num10", core_if.o_num, 10);
    ack_done("t2.a");
    step("t2.next");
    check("t2.num2", core_if.o_num, 2);
    ack_done("t2.b");
    check("t2.pend_empty", pend, 0);

    // 3: masked pending waits for unmask
    mask_wr = 1'b1; mask_data = '0; step("t3.mask0"); mask_wr = 1'b0;
    pulse(0, "t3");
    step("t3.w1");
    step("t3.w2");
    check("t3.pend0", pend[0], 1'b1);
    check("t3.noreq", core_if.o_req, 1'b0);
    mask_wr = 1'b1; mask_data = 11'd1; step("t3.mask1"); mask_wr = 1'b0;
    step("t3.sel");
    check("t3.req", core_if.o_req, 1'b1);
    check("t3.num1", core_if.o_num, 1);
    ack_done("t3");
    mask_wr = 1'b1; mask_data = '1; step("t3.maskall"); mask_wr = 1'b0;

    // 4: commitment while in REQ
    pulse(2, "t4");
    step("t4.sel");
    check("t4.num3", core_if.o_num, 3);
    irq[10] = 1'b1; core_if.i_gie = 1'b0;
    step("t4.hold1");
    irq[10] = 1'b0;
    step("t4.hold2");
    check("t4.num3_frozen", core_if.o_num, 3);
    check("t4.req_held", core_if.o_req, 1'b1);
    core_if.i_gie = 1'b1;
    ack_done("t4");
    step("t4.next");
    check("t4.num11", core_if.o_num, 11);
    ack_done("t4.b");

    // 5: re-trigger during ACTIVE, stray ack ignored
    pulse(5, "t5");
    step("t5.sel");
    core_if.i_ack = 1'b1; step("t5.ack"); core_if.i_ack = 1'b0;
    check("t5.active6", core_if.o_num, 6);
    irq[5] = 1'b1; core_if.i_ack = 1'b1;
    step("t5.retrig");
    irq[5] = 1'b0; core_if.i_ack = 1'b0;
    check("t5.still_active", core_if.o_active, 1'b1);
    check("t5.pend5", pend[5], 1'b1);
    core_if.i_done = 1'b1; step("t5.done"); core_if.i_done = 1'b0;
    step("t5.again");
    check("t5.req6", core_if.o_num, 6);
    ack_done("t5.b");

    // 6: async reset mid-REQ, line held high across release
    pulse(7, "t6");
    step("t6.sel");
    check("t6.in_req", core_if.o_req, 1'b1);
    rstn = 1'b0;
    #1;
    model_reset();
    compare_all("t6.async");
    irq[2] = 1'b1;
    #1;
    rstn = 1'b1;
    step("t6.first");
    check("t6.pend2", pend[2], 1'b1);
    check("t6.mask_lost", core_if.o_req, 1'b0);
    step("t6.held");
    irq = '0;

    // Random traffic against the model
    mask_wr = 1'b1; mask_data = '1; step("rnd.mask"); mask_wr = 1'b0;
    for (int c = 0; c < 500; c++) begin
      irq            = N'($urandom & $urandom & $urandom);
      mask_wr        = ($urandom_range(0, 7) == 0);
      mask_data      = N'($urandom | $urandom);
      core_if.i_gie  = ($urandom_range(0, 7) != 0);
      core_if.i_ack  = ($urandom_range(0, 2) == 0);
      core_if.i_done = ($urandom_range(0, 3) == 0);
      step("rnd");
    end
    irq = '0; mask_wr = 1'b0; core_if.i_ack = 1'b0; core_if.i_done = 1'b0;

    // 16-source build: top line encodes as 16
    mask_wr16 = 1'b1; mask_data16 = '1; core_if16.i_gie = 1'b1;
    @(posedge clk); #1;
    mask_wr16 = 1'b0; irq16[15] = 1'b1;
    @(posedge clk); #1;
    irq16 = '0;
    check("n16.pend15", pend16[15], 1'b1);
    @(posedge clk); #1;
    check("n16.req", core_if16.o_req, 1'b1);
    check("n16.num16", core_if16.o_num, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
